pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
Fetch-stage PC generator with a parametrised pattern history table (PHT) of 2-bit saturating counters, indexed by PC. It is the successor to the single-counter BNE predictor. It predicts BEQ and BNE, selectable by MODE (always-not-taken / dynamic / static BTFN), and takes resolution and redirect from ID. It sits between CTRL/ID and instruction ROM and drives the fetch address and ROM chip enable.

Parameters:
ADDR_W, 32, PC and target width
IDX_W, 6, PHT index bits (2^IDX_W entries, index = pc[IDX_W+1:2])
CNT_INIT, 2'b10, reset value of every PHT counter (weakly taken)
MODE, 1, 0 = always not-taken, 1 = dynamic PHT, 2 = static backward-taken/forward-not-taken
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stall  in  6  CTRL stall vector; stall[0] freezes PC
fetch_inst  in  32  ROM instruction at current pc (combinational ROM read)
resolve_valid  in  1  one-cycle pulse: branch resolved in ID
resolve_pc  in  ADDR_W  address of resolved branch
resolve_taken  in  1  actual direction
redirect  in  1  misprediction; load redirect_target
redirect_target  in  ADDR_W  correct next PC
pc  out  ADDR_W  fetch address
ce  out  1  ROM chip enable
pred_taken  out  1  prediction made for the instruction fetched last cycle
pred_count  out  CNT_W  number of predicted branches
mispred_count  out  CNT_W  number of redirects

Behaviour:
- Reset (async, rst=1): pc=0, ce=0, pred_taken=0, all PHT entries=CNT_INIT, both counters=0.
- ce: 0 while rst is high; goes to 1 on the first clk edge after rst deasserts; stays 1.
- While ce=0: pc holds 0 and no PHT update, prediction or counting takes place.
- Branch decode: fetch_inst[31:26] equal to EXE_BEQ (000100) or EXE_BNE (000101). Target = pc + 4 + {sext(imm16), 2'b00}, computed mod 2^ADDR_W.
- Prediction (combinational): MODE 0 gives 0. MODE 1 gives PHT[pc idx][1]. MODE 2 gives imm16[15] (backward = taken). Non-branch instructions always predict 0.
- Next PC, evaluated only when stall[0]=0. Priority order:
  - redirect: pc <= redirect_target; pred_taken <= 0.
  - branch predicted taken: pc <= target; pred_taken <= 1.
  - otherwise: pc <= pc+4; pred_taken <= 0.
- Stall: when stall[0]=1, pc and pred_taken hold. A redirect during stall is ignored; ID holds redirect asserted until the stall clears.
- PHT update: on resolve_valid, independent of stall[0] and MODE. Counter at resolve_pc[IDX_W+1:2] increments if taken and decrements otherwise, saturating at 00 and 11.
- Read/write collision: same-index update and prediction in one cycle means the prediction uses the pre-update value.
- Counters, both saturating at all-ones:
  - pred_count increments on each cycle that stall[0]=0, no redirect, and fetch_inst is a branch.
  - mispred_count increments on each cycle that redirect=1 and stall[0]=0.
- Reset mid-operation: immediate return to reset state, including PHT contents.
- Latency: prediction is applied to pc on the same edge that consumes fetch_inst (zero bubble). Redirect takes effect on the next edge.

Decomposition:
- Opcodes EXE_BEQ/EXE_BNE, Zero/One, ZeroWord and the MODE encodings (MODE_NT, MODE_DYN, MODE_BTFN) live in shared defines.v.
- Sub-module bht_table holds the PHT array, async reset, read port (pc index) and saturating update port (resolve index, taken). It is parametrised by IDX_W and CNT_INIT.

Test Plan:
- Reset then release: rst=1 gives pc=0, ce=0. First edge after release gives ce=1. Subsequent edges give pc 0,4,8,... for non-branch fetch_inst.
- MODE=1, CNT_INIT=10, pc=0x20, fetch_inst=BNE imm=0x0003 → next pc=0x30, pred_taken=1, pred_count=1.
- Counter training: three resolve_valid pulses with resolve_pc=0x20 and taken=0 → entry 10→01→00→00. BNE at 0x20 then predicts not-taken: pc=0x24, pred_taken=0.
- Redirect: redirect=1, target=0x100, with a predicted-taken branch in the same cycle → pc=0x100, pred_taken=0, mispred_count increments by 1. With stall[0]=1 the same stimulus leaves pc unchanged.
- MODE=2: BEQ imm=0xFFFE at pc=0x40 → pc=0x3C. BEQ imm=0x0002 at pc=0x40 → pc=0x44.
- Collision: resolve_valid for index 8 (taken=1, counter 01) in the same cycle as a BNE fetched at index 8 → prediction uses 01 (not-taken), pc+4. The next fetch at index 8 sees 10 and predicts taken.

Source files
------------

// File: rtl/pc_predict_unit_pkg.sv
// Shared opcodes, constants and prediction-mode encodings for the fetch PC predictor.
package pc_predict_unit_pkg;

  localparam logic [5:0]  EXE_BEQ   = 6'b000100;
  localparam logic [5:0]  EXE_BNE   = 6'b000101;
  localparam logic        ZERO      = 1'b0;
  localparam logic        ONE       = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam int unsigned MODE_NT   = 0;
  localparam int unsigned MODE_DYN  = 1;
  localparam int unsigned MODE_BTFN = 2;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == EXE_BEQ) || (op == EXE_BNE);
  endfunction

endpackage

// File: rtl/pc_predict_unit_bht_table.sv
// Pattern history table: 2-bit saturating counters, async reset, combinational
// read of the taken bit and one saturating update port.
module pc_predict_unit_bht_table #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0] r_pht [DEPTH];

  // Read sees the pre-update value on a same-index collision.
  assign rd_taken_c = r_pht[rd_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pht[i] <= CNT_INIT;
      end
    end else if (wr_en) begin
      if (wr_taken && (r_pht[wr_idx] != 2'b11)) begin
        r_pht[wr_idx] <= r_pht[wr_idx] + 2'd1;
      end else if (!wr_taken && (r_pht[wr_idx] != 2'b00)) begin
        r_pht[wr_idx] <= r_pht[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generator with BEQ/BNE prediction (not-taken, PHT or BTFN),
// ID redirect handling and saturating prediction/misprediction counters.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b10,
  parameter int unsigned MODE     = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [31:0]       fetch_inst,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic              resolve_taken,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pred_taken,
  output logic [CNT_W-1:0]  pred_count,
  output logic [CNT_W-1:0]  mispred_count
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ce;
  logic              r_pred_taken;
  logic [CNT_W-1:0]  r_pred_count;
  logic [CNT_W-1:0]  r_mispred_count;

  logic [15:0]       w_imm;
  logic              w_is_br;
  logic [ADDR_W-1:0] w_target;
  logic              w_pht_taken;
  logic              w_pred;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_next_pred;
  logic              w_advance;
  logic              w_unused;

  assign w_imm     = fetch_inst[15:0];
  assign w_is_br   = is_branch(fetch_inst[31:26]);
  assign w_target  = r_pc + ADDR_W'(4) + ADDR_W'($signed({w_imm, 2'b00}));
  assign w_advance = r_ce && !stall[0];
  assign w_unused  = &{1'b0, stall[5:1], fetch_inst[25:16], resolve_pc[1:0],
                       resolve_pc[ADDR_W-1:IDX_W+2]};

  pc_predict_unit_bht_table #(
    .IDX_W   (IDX_W),
    .CNT_INIT(CNT_INIT)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (r_pc[IDX_W+1:2]),
    .rd_taken_c(w_pht_taken),
    .wr_en     (resolve_valid && r_ce),
    .wr_idx    (resolve_pc[IDX_W+1:2]),
    .wr_taken  (resolve_taken)
  );

  // Direction prediction for the instruction at the current fetch address.
  always_comb begin
    w_pred = ZERO;
    if (w_is_br) begin
      case (MODE)
        MODE_DYN:  w_pred = w_pht_taken;
        MODE_BTFN: w_pred = w_imm[15];
        default:   w_pred = ZERO;
      endcase
    end
  end

  // Redirect beats prediction, prediction beats sequential fetch.
  always_comb begin
    w_next_pc   = r_pc + ADDR_W'(4);
    w_next_pred = ZERO;
    if (redirect) begin
      w_next_pc = redirect_target;
    end else if (w_pred) begin
      w_next_pc   = w_target;
      w_next_pred = ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc            <= ADDR_W'(ZERO_WORD);
      r_ce            <= ZERO;
      r_pred_taken    <= ZERO;
      r_pred_count    <= '0;
      r_mispred_count <= '0;
    end else begin
      r_ce <= ONE;
      if (w_advance) begin
        r_pc         <= w_next_pc;
        r_pred_taken <= w_next_pred;
        if (redirect && (r_mispred_count != '1)) begin
          r_mispred_count <= r_mispred_count + CNT_W'(1);
        end
        if (!redirect && w_is_br && (r_pred_count != '1)) begin
          r_pred_count <= r_pred_count + CNT_W'(1);
        end
      end
    end
  end

  assign pc            = r_pc;
  assign ce            = r_ce;
  assign pred_taken    = r_pred_taken;
  assign pred_count    = r_pred_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: one instance per MODE, a behavioural model checked
// every cycle, plus literal expectations from the directed scenarios.
module tb_pc_predict_unit;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BNE3   = 32'h1400_0003;
  localparam logic [31:0] BEQ_M2 = 32'h1000_FFFE;
  localparam logic [31:0] BEQ_P2 = 32'h1000_0002;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic [31:0] fetch_inst = '0;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;

  logic [31:0] d_pc   [3];
  logic        d_ce   [3];
  logic        d_pred [3];
  logic [31:0] d_pcnt [3];
  logic [31:0] d_mis  [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      pc_predict_unit #(
        .ADDR_W(32), .IDX_W(6), .CNT_INIT(2'b10), .MODE(g), .CNT_W(32)
      ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .fetch_inst     (fetch_inst),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .resolve_taken  (resolve_taken),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .pc             (d_pc[g]),
        .ce             (d_ce[g]),
        .pred_taken     (d_pred[g]),
        .pred_count     (d_pcnt[g]),
        .mispred_count  (d_mis[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;
  bit m_valid = 1'b0;

  logic [31:0] m_pc   [3];
  logic        m_ce   [3];
  logic        m_pred [3];
  logic [31:0] m_pcnt [3];
  logic [31:0] m_mis  [3];
  int          pht    [3][64];

  logic [15:0] t_imm;
  logic [31:0] t_tgt;
  bit          t_br;
  bit          t_p;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[mode%0d] t=%0t act=%h exp=%h", nm, inst, $time, act, exp);
    end
  endtask

  // Reference model: instance i runs in MODE i.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pc[i] = 0; m_ce[i] = 0; m_pred[i] = 0; m_pcnt[i] = 0; m_mis[i] = 0;
        for (int k = 0; k < 64; k++) pht[i][k] = 2;
        m_valid = 1'b1;
      end else if (!m_ce[i]) begin
        m_ce[i] = 1;
      end else begin
        t_imm = fetch_inst[15:0];
        t_br  = (fetch_inst[31:26] == 6'd4) || (fetch_inst[31:26] == 6'd5);
        t_tgt = m_pc[i] + 32'd4 + 32'($signed(t_imm) * 4);
        t_p   = 0;
        if (t_br) begin
          if (i == 1) t_p = pht[i][(m_pc[i] / 4) % 64] >= 2;
          if (i == 2) t_p = t_imm[15];
        end
        if (!stall[0]) begin
          if (redirect) begin
            m_pc[i] = redirect_target; m_pred[i] = 0;
            if (m_mis[i] != 32'hFFFF_FFFF) m_mis[i]++;
          end else begin
            if (t_br && m_pcnt[i] != 32'hFFFF_FFFF) m_pcnt[i]++;
            m_pred[i] = t_p;
            m_pc[i]   = t_p ? t_tgt : m_pc[i] + 32'd4;
          end
        end
        if (resolve_valid) begin
          if (resolve_taken) pht[i][(resolve_pc / 4) % 64] = (pht[i][(resolve_pc / 4) % 64] == 3) ? 3 : pht[i][(resolve_pc / 4) % 64] + 1;
          else               pht[i][(resolve_pc / 4) % 64] = (pht[i][(resolve_pc / 4) % 64] == 0) ? 0 : pht[i][(resolve_pc / 4) % 64] - 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid && !done) begin
      for (int i = 0; i < 3; i++) begin
        check("pc", i, d_pc[i], m_pc[i]);
        check("ce", i, 32'(d_ce[i]), 32'(m_ce[i]));
        check("pred_taken", i, 32'(d_pred[i]), 32'(m_pred[i]));
        check("pred_count", i, d_pcnt[i], m_pcnt[i]);
        check("mispred_count", i, d_mis[i], m_mis[i]);
      end
    end
  end

  task automatic step(input logic [31:0] fi, input logic st, input logic rd, input logic [31:0] tgt,
                      input logic rv, input logic [31:0] rpc, input logic rt);
    @(negedge clk);
    fetch_inst = fi; stall = {5'b10100, st}; redirect = rd; redirect_target = tgt;
    resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      check("lit_rst_pc", i, d_pc[i], 32'h0);
      check("lit_rst_ce", i, 32'(d_ce[i]), 32'h0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    check("lit_rel_ce", 1, 32'(d_ce[1]), 32'h1);
    check("lit_rel_pc", 1, d_pc[1], 32'h0);
    step(NOP, 0, 0, 0, 0, 0, 0);
    check("lit_seq_pc4", 0, d_pc[0], 32'h4);
    repeat (7) step(NOP, 0, 0, 0, 0, 0, 0);
    check("lit_seq_pc20", 1, d_pc[1], 32'h20);

    // Dynamic BNE at 0x20 with weakly-taken entry.
    step(BNE3, 0, 0, 0, 0, 0, 0);
    check("lit_dyn_pc", 1, d_pc[1], 32'h30);
    check("lit_dyn_pred", 1, 32'(d_pred[1]), 32'h1);
    check("lit_dyn_pcnt", 1, d_pcnt[1], 32'h1);
    check("lit_nt_pc", 0, d_pc[0], 32'h24);
    check("lit_btfn_fwd_pc", 2, d_pc[2], 32'h24);

    // Training entry 8 down while stalled at 0x20.
    step(NOP, 0, 1, 32'h20, 0, 0, 0);
    repeat (3) step(NOP, 1, 0, 0, 1, 32'h20, 0);
    check("lit_stall_pc", 1, d_pc[1], 32'h20);
    step(BNE3, 0, 0, 0, 0, 0, 0);
    check("lit_trained_pc", 1, d_pc[1], 32'h24);
    check("lit_trained_pred", 1, 32'(d_pred[1]), 32'h0);

    // Redirect ignored under stall, then honoured over a taken prediction.
    step(BNE3, 1, 1, 32'h100, 0, 0, 0);
    check("lit_rd_stall_pc", 1, d_pc[1], 32'h24);
    check("lit_rd_stall_mis", 1, d_mis[1], 32'h1);
    step(BNE3, 0, 1, 32'h100, 0, 0, 0);
    check("lit_rd_pc", 1, d_pc[1], 32'h100);
    check("lit_rd_pred", 1, 32'(d_pred[1]), 32'h0);
    check("lit_rd_mis", 1, d_mis[1], 32'h2);

    // Static BTFN at 0x40.
    step(NOP, 0, 1, 32'h40, 0, 0, 0);
    step(BEQ_M2, 0, 0, 0, 0, 0, 0);
    check("lit_btfn_back_pc", 2, d_pc[2], 32'h3C);
    check("lit_btfn_back_pred", 2, 32'(d_pred[2]), 32'h1);
    step(NOP, 0, 1, 32'h40, 0, 0, 0);
    step(BEQ_P2, 0, 0, 0, 0, 0, 0);
    check("lit_btfn_fwd2_pc", 2, d_pc[2], 32'h44);
    check("lit_dyn_idx16_pc", 1, d_pc[1], 32'h4C);

    // Same-index read/write collision on entry 8 (counter 01 -> 10).
    step(NOP, 0, 1, 32'h20, 1, 32'h20, 1);
    step(BNE3, 0, 0, 0, 1, 32'h20, 1);
    check("lit_coll_pc", 1, d_pc[1], 32'h24);
    step(NOP, 0, 1, 32'h20, 0, 0, 0);
    step(BNE3, 0, 0, 0, 0, 0, 0);
    check("lit_coll_after_pc", 1, d_pc[1], 32'h30);

    // Mid-run reset restores the PHT.
    repeat (2) step(NOP, 1, 0, 0, 1, 32'h20, 0);
    @(negedge clk);
    rst = 1'b1; fetch_inst = NOP; stall = '0; redirect = 0; resolve_valid = 0;
    @(posedge clk); #2;
    check("lit_mid_rst_pc", 1, d_pc[1], 32'h0);
    check("lit_mid_rst_ce", 1, 32'(d_ce[1]), 32'h0);
    check("lit_mid_rst_mis", 1, d_mis[1], 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    step(NOP, 0, 1, 32'h20, 0, 0, 0);
    step(BNE3, 0, 0, 0, 0, 0, 0);
    check("lit_post_rst_pc", 1, d_pc[1], 32'h30);
    check("lit_post_rst_pcnt", 1, d_pcnt[1], 32'h1);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
